// File: rtl/sync_fire_pkg.sv
// Shared types and constants for the synchronous firing scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sync_fire_pkg;

    typedef enum logic [1:0] {
        MODE_RR   = 2'd0,
        MODE_LFSR = 2'd1,
        MODE_EXT  = 2'd2,
        MODE_HOLD = 2'd3
    } mode_t;

    // Galois form of x^16+x^14+x^13+x^11+1, right-shifting.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/fire_rotate_pick.sv
// Rotating-priority search: first set bit of vec at or after start, wrapping.
// Latency: combinational.
// Backpressure: none.
module fire_rotate_pick #(
    parameter int N = 8
) (
    input  logic [N-1:0]         vec,
    input  logic [$clog2(N)-1:0] start,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            int            p;
            logic [IW-1:0] pi;
            p = int'(start) + i;
            if (p >= N) p = p - N;
            pi = p[IW-1:0];
            if (!found && vec[pi]) begin
                found = 1'b1;
                idx   = pi;
            end
        end
    end

endmodule

// File: rtl/sync_fire_scheduler.sv
// Picks at most one excited signal per cycle to fire; tracks progress and deadlock.
// Latency: 1 cycle from excitation to registered fire outputs.
// Backpressure: none; a just-fired signal is masked for one cycle until its flop updates.
module sync_fire_scheduler
    import sync_fire_pkg::*;
#(
    parameter int          N               = 8,
    parameter int          IDXW            = $clog2(N),
    parameter int          DEADLOCK_CYCLES = 16,
    parameter logic [15:0] LFSR_SEED       = LFSR_DEFAULT_SEED
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      mode,
    input  logic [IDXW-1:0] ext_idx,
    input  logic [N-1:0]    precap,
    input  logic [N-1:0]    state,
    output logic            fire_valid,
    output logic [IDXW-1:0] fire_idx,
    output logic [N-1:0]    fire_onehot,
    output logic            quiescent,
    output logic            deadlock,
    output logic [15:0]     fire_count
);

    localparam int              SW        = $clog2(DEADLOCK_CYCLES + 1);
    localparam logic [SW-1:0]   DC_W      = DEADLOCK_CYCLES[SW-1:0];
    localparam logic [IDXW:0]   N_W       = N[IDXW:0];
    localparam logic [IDXW-1:0] LAST      = IDXW'(N - 1);
    localparam logic [15:0]     SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [IDXW-1:0] ptr;
    logic [15:0]     lfsr;
    logic [SW-1:0]   stall;

    logic [N-1:0]    excited;
    logic [N-1:0]    cand;
    logic [IDXW-1:0] rr_start;
    logic [IDXW-1:0] lfsr_start;
    logic [IDXW-1:0] pick_start;
    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    mode_t           mode_e;

    logic            sel_vld;
    logic [IDXW-1:0] sel_idx;
    logic [N-1:0]    sel_oh;
    logic [SW-1:0]   stall_nxt;

    assign mode_e    = mode_t'(mode);
    assign excited   = precap ^ state;
    assign quiescent = ~|excited;
    // fire_onehot is zero whenever fire_valid is low, so it doubles as the mask.
    assign cand      = excited & ~fire_onehot;

    assign rr_start   = (ptr == LAST) ? '0 : ptr + IDXW'(1);
    assign lfsr_start = ({1'b0, lfsr[IDXW-1:0]} >= N_W) ? lfsr[IDXW-1:0] - N_W[IDXW-1:0]
                                                        : lfsr[IDXW-1:0];
    assign pick_start = (mode_e == MODE_LFSR) ? lfsr_start : rr_start;

    fire_rotate_pick #(.N(N)) u_pick (
        .vec   (cand),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        sel_oh  = '0;
        case (mode_e)
            MODE_RR, MODE_LFSR: begin
                sel_vld = pick_found;
                sel_idx = pick_idx;
            end
            MODE_EXT: begin
                if (({1'b0, ext_idx} < N_W) && cand[ext_idx]) begin
                    sel_vld = 1'b1;
                    sel_idx = ext_idx;
                end
            end
            default: ;
        endcase
        if (sel_vld) sel_oh[sel_idx] = 1'b1;

        stall_nxt = '0;
        if (quiescent) stall_nxt = (stall == DC_W) ? stall : stall + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fire_valid  <= 1'b0;
            fire_idx    <= '0;
            fire_onehot <= '0;
            ptr         <= LAST;
            lfsr        <= SEED_EFF;
            stall       <= '0;
            deadlock    <= 1'b0;
            fire_count  <= '0;
        end else begin
            fire_valid  <= sel_vld;
            fire_idx    <= sel_idx;
            fire_onehot <= sel_oh;
            if (sel_vld && mode_e == MODE_RR) ptr <= sel_idx;
            lfsr  <= lfsr_step(lfsr);
            stall <= stall_nxt;
            if (stall_nxt == DC_W) deadlock <= 1'b1;
            if (fire_valid && fire_count != 16'hFFFF) fire_count <= fire_count + 16'd1;
        end
    end

endmodule
